// File: rtl/pmem_arbiter.sv
// pmem_arbiter: arbitrates I-cache and D-cache line requests onto one physical memory port.
module pmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              instr_mem_resp_o,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              data_mem_resp_o,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, RESP_I, RESP_D} state_e;
  state_e state_q, state_d;
  logic last_d_q, last_d_d, wr_q, wr_d, grant_d, grant_i, busy;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  // data side wins ties unless it was served last
  assign grant_d = (d_read || d_write) && (!i_read || !last_d_q);
  assign grant_i = i_read && !grant_d;
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = D_BUSY;
          last_d_d = 1'b1;
          wr_d     = d_write;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
        end else if (grant_i) begin
          state_d  = I_BUSY;
          last_d_d = 1'b0;
          wr_d     = 1'b0;
          addr_d   = i_addr;
        end
      end
      I_BUSY: if (pmem_resp) begin
        state_d   = RESP_I;
        i_rdata_d = pmem_rdata;
      end
      D_BUSY: if (pmem_resp) begin
        state_d   = RESP_D;
        d_rdata_d = wr_q ? d_rdata_q : pmem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign busy             = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign pmem_read        = !rst && busy && !wr_q;
  assign pmem_write       = !rst && busy && wr_q;
  assign pmem_addr        = addr_q;
  assign pmem_wdata       = wdata_q;
  assign i_rdata          = i_rdata_q;
  assign d_rdata          = d_rdata_q;
  assign instr_mem_resp_o = !rst && (state_q == RESP_I);
  assign data_mem_resp_o  = !rst && (state_q == RESP_D);
endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache-line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, physical address width in bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port i_read, input, 1, instruction-cache line read request.
REQ-006 SHALL have port i_addr, input, ADDR_W, instruction-cache line address.
REQ-007 SHALL have port i_rdata, output, LINE_W, line returned to the instruction cache.
REQ-008 SHALL have port instr_mem_resp_o, output, 1, instruction-side completion pulse.
REQ-009 SHALL have ports d_read and d_write, input, 1 each, data-cache line read and write-back requests.
REQ-010 SHALL have ports d_addr (ADDR_W) and d_wdata (LINE_W), input, data-side address and write line.
REQ-011 SHALL have port d_rdata, output, LINE_W, line returned to the data cache.
REQ-012 SHALL have port data_mem_resp_o, output, 1, data-side completion pulse.
REQ-013 SHALL have ports pmem_read and pmem_write, output, 1 each, physical memory commands.
REQ-014 SHALL have ports pmem_addr (ADDR_W) and pmem_wdata (LINE_W), output, physical memory address and write line.
REQ-015 SHALL have ports pmem_rdata (LINE_W) and pmem_resp (1), input, physical memory read line and completion.

Function
REQ-016 SHALL implement FSM states IDLE, I_BUSY, D_BUSY, RESP_I, RESP_D.
REQ-017 Requests SHALL be level-sensitive, held by the requester until its resp pulse.
REQ-018 In IDLE with only the data side requesting, the FSM SHALL go to D_BUSY; with only the instruction side requesting, to I_BUSY; with no request, it SHALL stay in IDLE.
REQ-019 In IDLE with both sides requesting, the data side SHALL win unless last_was_d=1, in which case the instruction side SHALL win (anti-starvation).
REQ-020 last_was_d SHALL be set on entry to D_BUSY and cleared on entry to I_BUSY.
REQ-021 On the grant edge, address, write data, and command (d_write takes precedence over d_read if both are high) SHALL be latched; pmem_* outputs SHALL be driven only from the latched values.
REQ-022 In I_BUSY/D_BUSY, exactly one of pmem_read/pmem_write SHALL be high, held until pmem_resp.
REQ-023 On pmem_resp in I_BUSY, pmem_rdata SHALL be captured into i_rdata and the FSM SHALL go to RESP_I; the D_BUSY analogue SHALL go to RESP_D (capture only on reads; d_rdata is unchanged on writes).
REQ-024 In RESP_I/RESP_D, the matching resp output SHALL be high for exactly one cycle, with pmem_read/pmem_write low; the next state SHALL be IDLE.
REQ-025 Requests SHALL be ignored during RESP_*; arbitration SHALL resume in the IDLE cycle that follows.
REQ-026 Minimum latency SHALL be: request seen in IDLE at edge N, pmem command high from N, pmem_resp at edge M, resp high in cycle after M; total is pmem latency + 2 cycles.
REQ-027 i_rdata/d_rdata SHALL hold their last captured value until the next capture on the same side.
REQ-028 Both resp outputs SHALL never be high in the same cycle.
REQ-029 pmem_resp outside I_BUSY/D_BUSY SHALL be ignored.
REQ-030 A requester dropping its request mid-transaction SHALL NOT abort it; the transaction completes and resp still pulses.

Reset
REQ-031 On a rising edge with rst=1, the FSM SHALL be set to IDLE, last_was_d to 0, and all latches, i_rdata and d_rdata to 0.
REQ-032 While in reset, pmem_read, pmem_write, instr_mem_resp_o and data_mem_resp_o SHALL be 0.
REQ-033 A reset asserted mid-transaction SHALL drop the pmem command on that edge and leave no pending resp.

Verification
REQ-034 Single I-read: i_read=1, i_addr=0x0000_0040, pmem_resp after 3 cycles with pmem_rdata=0xA5..A5 -> pmem_read high 3 cycles, pmem_addr=0x40, i_rdata=0xA5..A5, 1-cycle instr_mem_resp_o.
REQ-035 Collision: i_read and d_read both high from reset -> D served first, then I; no resp overlap; each resp is 1 cycle.
REQ-036 Starvation: d_read held continuously and i_read high -> services alternate D, I, D; I is granted within one D transaction.
REQ-037 Write-back: d_write=1, d_addr=0x100, d_wdata=0x1234 -> pmem_write=1, pmem_wdata=0x1234; d_rdata is unchanged; data_mem_resp_o pulses once.
REQ-038 Reset mid-operation: rst=1 during D_BUSY -> next cycle pmem_write=0, no data_mem_resp_o; a fresh i_read afterward is served normally.
REQ-039 Spurious pmem_resp in IDLE -> no state change and no resp output.
